datamemory_stream_loader: RTL

//  Sequential front-end for the single-cycle datamemory (10-bit word address, 32-bit data, async read).
//  On a start command, it either bursts a valid/ready input stream into consecutive memory words (fill),
//  or bursts consecutive memory words out on a valid/ready output stream (drain).

---
 rtl/datamemory_stream_loader_if.sv | 38 +++
 rtl/datamemory_stream_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/datamemory_stream_loader_if.sv
// Command, stream and datamemory-port bundle for datamemory_stream_loader.
// master = the loader itself, slave = whatever sits around it (host, streams, memory).
interface datamemory_stream_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
);
  logic              start;
  logic              dir;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic              memread;
  logic              memwrite;
  logic [DATA_W-1:0] readdata;
  logic [DATA_W-1:0] checksum;

  modport master (
    input  start, dir, base_addr, length, in_data, in_valid, out_ready, readdata,
    output busy, done, in_ready, out_data, out_valid, address, writedata,
           memread, memwrite, checksum
  );

  modport slave (
    output start, dir, base_addr, length, in_data, in_valid, out_ready, readdata,
    input  busy, done, in_ready, out_data, out_valid, address, writedata,
           memread, memwrite, checksum
  );
endinterface

// File: rtl/datamemory_stream_loader.sv
// Bursts a valid/ready stream into datamemory (fill) or memory words out to a stream (drain).
// Define CHECKSUM_EN to get a running sum of transferred words on checksum; otherwise it is tied to 0.
module datamemory_stream_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input logic                        clk,
  input logic                        reset,
  datamemory_stream_loader_if.master bus
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg;
  logic [ADDR_W-1:0] address_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  cnt_reg;
  logic [LEN_W-1:0]  issued_reg;
  logic [DATA_W-1:0] writedata_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              memwrite_reg;
  logic              memread_reg;
  logic              out_valid_reg;

  logic              busy, done, in_ready;
  logic              start_accept, fill_accept, capture, out_accept, last_out;
  logic [LEN_W-1:0]  len_clamped;

  assign len_clamped = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            state_next = DONE;
          end else begin
            state_next = bus.dir ? DRAIN : FILL;
          end
        end
      end
      // Wait one cycle past the last accept so the final write strobe lands before done.
      FILL:    if (cnt_reg == len_reg) state_next = DONE;
      DRAIN:   if (last_out) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    in_ready     = 1'b0;
    start_accept = 1'b0;
    capture      = 1'b0;
    out_accept   = 1'b0;
    case (state_reg)
      IDLE:  start_accept = bus.start;
      FILL: begin
        busy     = 1'b1;
        in_ready = (cnt_reg < len_reg);
      end
      DRAIN: begin
        busy       = 1'b1;
        capture    = (!out_valid_reg || bus.out_ready) && (issued_reg < len_reg);
        out_accept = out_valid_reg && bus.out_ready;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
    fill_accept = in_ready && bus.in_valid;
    last_out    = out_accept && (cnt_reg == len_reg - LEN_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg       <= '0;
      address_reg   <= '0;
      len_reg       <= '0;
      cnt_reg       <= '0;
      issued_reg    <= '0;
      writedata_reg <= '0;
      out_data_reg  <= '0;
      memwrite_reg  <= 1'b0;
      memread_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      memwrite_reg <= fill_accept;
      memread_reg  <= (state_next == DRAIN);

      if (start_accept) begin
        ptr_reg    <= bus.base_addr;
        cnt_reg    <= '0;
        issued_reg <= '0;
        len_reg    <= len_clamped;
        if (bus.dir) begin
          address_reg <= bus.base_addr;
        end
      end

      if (fill_accept) begin
        address_reg   <= ptr_reg;
        writedata_reg <= bus.in_data;
        ptr_reg       <= ptr_reg + ADDR_W'(1);
        cnt_reg       <= cnt_reg + LEN_W'(1);
      end

      // In drain the address register runs one word ahead of out_data, tracking ptr.
      if (capture) begin
        out_data_reg  <= bus.readdata;
        out_valid_reg <= 1'b1;
        ptr_reg       <= ptr_reg + ADDR_W'(1);
        address_reg   <= ptr_reg + ADDR_W'(1);
        issued_reg    <= issued_reg + LEN_W'(1);
      end else if (out_accept) begin
        out_valid_reg <= 1'b0;
      end

      if (out_accept) begin
        cnt_reg <= cnt_reg + LEN_W'(1);
      end
    end
  end

`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] checksum_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_reg <= '0;
    end else if (start_accept) begin
      checksum_reg <= '0;
    end else if (fill_accept) begin
      checksum_reg <= checksum_reg + bus.in_data;
    end else if (out_accept) begin
      checksum_reg <= checksum_reg + out_data_reg;
    end
  end

  assign bus.checksum = checksum_reg;
`else
  assign bus.checksum = '0;
`endif

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.address   = address_reg;
  assign bus.writedata = writedata_reg;
  assign bus.memread   = memread_reg;
  assign bus.memwrite  = memwrite_reg;

endmodule
